// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/opcode request and result/flags response channels of alu_pipe.
interface alu_pipe_if #(
  parameter int WIDTH = 8,
  parameter int OPW = 4
);
  logic in_valid, in_ready, out_valid, out_ready;
  logic jump_flag, zero_flag, carry_flag;
  logic [OPW-1:0] alu_op;
  logic [WIDTH-1:0] input1, input2, out;
  modport master(
    output in_valid, alu_op, input1, input2, out_ready,
    input in_ready, out_valid, out, jump_flag, zero_flag, carry_flag
  );
  modport slave(
    input in_valid, alu_op, input1, input2, out_ready,
    output in_ready, out_valid, out, jump_flag, zero_flag, carry_flag
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with single-cycle ops and an iterative shift-add MUL.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int OPW = 4
) (
  input logic clock,
  input logic reset_n,
  alu_pipe_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WV = WIDTH'(WIDTH);
  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_XOR = OPW'(1);
  localparam logic [OPW-1:0] OP_AND = OPW'(2);
  localparam logic [OPW-1:0] OP_ROL = OPW'(3);
  localparam logic [OPW-1:0] OP_MOV = OPW'(4);
  localparam logic [OPW-1:0] OP_LD = OPW'(5);
  localparam logic [OPW-1:0] OP_ST = OPW'(6);
  localparam logic [OPW-1:0] OP_BEQ = OPW'(7);
  localparam logic [OPW-1:0] OP_SUB = OPW'(8);
  localparam logic [OPW-1:0] OP_MUL = OPW'(9);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a, b, sh, res, result, mcand, mplier, acc, acc_nx;
  logic [2*WIDTH-1:0] rot;
  logic [WIDTH:0] sum;
  logic cy, jmp, legal, jump, zero, carry, valid, accept, is_mul;
  assign a = bus.input1;
  assign b = bus.input2;
  assign bus.in_ready = state == IDLE || (state == HOLD && bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign is_mul = bus.alu_op == OP_MUL;
  assign sum = {1'b0, a} + {1'b0, b};
  // rotate via a doubled word so any shift amount wraps the bits around
  assign sh = b % WV;
  assign rot = {a, a} << sh;
  assign acc_nx = mplier[0] ? acc + mcand : acc;
  assign bus.out = result;
  assign bus.out_valid = valid;
  assign bus.jump_flag = jump;
  assign bus.zero_flag = zero;
  assign bus.carry_flag = carry;
  always_comb begin
    res = '0;
    cy = 1'b0;
    jmp = 1'b0;
    legal = 1'b1;
    case (bus.alu_op)
      OP_ADD: {cy, res} = sum;
      OP_XOR: res = a ^ b;
      OP_AND: res = a & b;
      OP_ROL: res = rot[2*WIDTH-1:WIDTH];
      OP_MOV: res = b;
      OP_LD, OP_ST: res = a;
      OP_BEQ: jmp = a == b;
      OP_SUB: begin
        res = a - b;
        cy = a < b;
      end
      default: legal = 1'b0;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      result <= '0;
      jump <= 1'b0;
      zero <= 1'b0;
      carry <= 1'b0;
      valid <= 1'b0;
    end else if (state == BUSY) begin
      acc <= acc_nx;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) begin
        result <= acc_nx;
        zero <= acc_nx == '0;
        carry <= 1'b0;
        jump <= 1'b0;
        valid <= 1'b1;
        state <= HOLD;
      end
    end else if (accept && is_mul) begin
      state <= BUSY;
      cnt <= '0;
      acc <= '0;
      mcand <= a;
      mplier <= b;
      valid <= 1'b0;
    end else if (accept) begin
      result <= res;
      carry <= cy;
      jump <= jmp;
      zero <= legal && res == '0;
      valid <= 1'b1;
      state <= HOLD;
    end else if (state == HOLD && bus.out_ready) begin
      state <= IDLE;
      valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against a queue-based reference model.
module tb_alu_pipe;
  localparam int W = 8;
  localparam int M = (1 << W) - 1;
  typedef struct {int o; int j; int z; int c; int at;} exp_t;
  logic clock = 0;
  logic reset_n = 1;
  int asserts = 0, fails = 0, cyc = 0;
  exp_t q[$];
  exp_t ne;
  bit mv, mr, vld_exp;
  alu_pipe_if #(.WIDTH(W), .OPW(4)) bus();
  alu_pipe #(.WIDTH(W), .OPW(4)) dut(.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  function automatic exp_t model(int op, int a, int b);
    exp_t e;
    int sh;
    e = '{0, 0, 0, 0, 0};
    sh = b % W;
    case (op)
      0: begin e.o = (a + b) & M; e.c = (a + b) >> W; end
      1: e.o = a ^ b;
      2: e.o = a & b;
      3: e.o = ((a << sh) | (a >> (W - sh))) & M;
      4: e.o = b;
      5, 6: e.o = a;
      7: e.j = int'(a == b);
      8: begin e.o = (a - b) & M; e.c = int'(a < b); end
      9: e.o = (a * b) & M;
      default: ;
    endcase
    e.z = int'(op <= 9 && e.o == 0);
    return e;
  endfunction
  task automatic chk(string nm, int act, int exp);
    asserts++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // result becomes visible `at` edges: one for plain ops, WIDTH more for MUL
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) q.delete();
    else begin
      mv = q.size() > 0 && cyc >= q[0].at;
      mr = q.size() == 0 || (mv && bus.out_ready);
      cyc++;
      if (mv && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && mr) begin
        ne = model(int'(bus.alu_op), int'(bus.input1), int'(bus.input2));
        ne.at = cyc + (bus.alu_op == 9 ? W : 0);
        q.push_back(ne);
      end
    end
  end
  always @(negedge clock) begin
    if (reset_n) begin
      vld_exp = q.size() > 0 && cyc >= q[0].at;
      chk("out_valid", int'(bus.out_valid), int'(vld_exp));
      chk("in_ready", int'(bus.in_ready), int'(q.size() == 0 || (vld_exp && bus.out_ready)));
      if (vld_exp) begin
        chk("out", int'(bus.out), q[0].o);
        chk("jump_flag", int'(bus.jump_flag), q[0].j);
        chk("zero_flag", int'(bus.zero_flag), q[0].z);
        chk("carry_flag", int'(bus.carry_flag), q[0].c);
      end
    end
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic send(int op, int a, int b);
    int n = 0;
    bus.alu_op = 4'(op);
    bus.input1 = 8'(a);
    bus.input2 = 8'(b);
    bus.in_valid = 1;
    while (!bus.in_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("send_timeout", n, 0);
    step();
    bus.in_valid = 0;
  endtask
  task automatic expect_res(string nm, int o, int c, int z, int j, int lat);
    int n = 0;
    while (!bus.out_valid && n < 40) begin
      step();
      n++;
    end
    chk({nm, "_latency"}, n + 1, lat);
    chk({nm, "_out"}, int'(bus.out), o);
    chk({nm, "_carry"}, int'(bus.carry_flag), c);
    chk({nm, "_zero"}, int'(bus.zero_flag), z);
    chk({nm, "_jump"}, int'(bus.jump_flag), j);
  endtask
  initial begin
    bus.in_valid = 0;
    bus.out_ready = 1;
    bus.alu_op = '0;
    bus.input1 = '0;
    bus.input2 = '0;
    #1 reset_n = 0;
    step();
    step();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out", int'(bus.out), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_flags", int'({bus.jump_flag, bus.zero_flag, bus.carry_flag}), 0);
    reset_n = 1;
    step();
    send(0, 'hFF, 'h01); expect_res("add_ff_01", 'h00, 1, 1, 0, 1);
    send(8, 'h05, 'h07); expect_res("sub_5_7", 'hFE, 1, 0, 0, 1);
    send(8, 'h07, 'h05); expect_res("sub_7_5", 'h02, 0, 0, 0, 1);
    send(3, 'h81, 1); expect_res("rol_81_1", 'h03, 0, 0, 0, 1);
    send(3, 'h81, 9); expect_res("rol_81_9", 'h03, 0, 0, 0, 1);
    send(3, 'hA5, 8); expect_res("rol_a5_8", 'hA5, 0, 0, 0, 1);
    send(7, 'h3C, 'h3C); expect_res("beq_eq", 0, 0, 1, 1, 1);
    send(7, 'h3C, 'h3D); expect_res("beq_ne", 0, 0, 1, 0, 1);
    send(9, 13, 11); expect_res("mul_13_11", 'h8F, 0, 0, 0, 9);
    send(9, 'h10, 'h10); expect_res("mul_16_16", 'h00, 0, 1, 0, 9);
    send(12, 'h12, 'h34); expect_res("illegal_op", 0, 0, 0, 0, 1);
    step();
    bus.out_ready = 0;
    send(0, 'h12, 'h34);
    for (int i = 0; i < 5; i++) begin
      chk("hold_out", int'(bus.out), 'h46);
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_in_ready", int'(bus.in_ready), 0);
      step();
    end
    bus.out_ready = 1;
    send(1, 'h0F, 'hF0); expect_res("xor_after_hold", 'hFF, 0, 0, 0, 1);
    send(9, 3, 5);
    repeat (3) step();
    reset_n = 0;
    #1;
    chk("midmul_rst_valid", int'(bus.out_valid), 0);
    chk("midmul_rst_out", int'(bus.out), 0);
    step();
    step();
    reset_n = 1;
    step();
    chk("post_rst_in_ready", int'(bus.in_ready), 1);
    chk("post_rst_valid", int'(bus.out_valid), 0);
    repeat (600) begin
      bus.out_ready = $urandom_range(3) != 0;
      bus.in_valid = $urandom_range(2) != 0;
      bus.alu_op = ($urandom_range(4) == 0) ? 4'd9 : 4'($urandom_range(15));
      bus.input1 = 8'($urandom);
      bus.input2 = ($urandom_range(3) == 0) ? bus.input1 : 8'($urandom);
      step();
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    repeat (20) step();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
